// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// adjust-field select codes and the BCD digit limits for a mod-60 field.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ADJUST = 2'd3
  } sw_state_t;

  localparam logic [2:0] ADJ_SEL_NONE = 3'b000;
  localparam logic [2:0] ADJ_SEL_SEC  = 3'b001;
  localparam logic [2:0] ADJ_SEL_MIN  = 3'b010;

  localparam logic [3:0] MAX_TENS  = 4'd5;
  localparam logic [3:0] MAX_UNITS = 4'd9;

  // Display digits are 5 bits wide with the top bit tied low.
  function automatic logic [4:0] to_digit(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// bcd_mod60: one two-digit BCD field counting 00..59.
// clear has priority over inc; carry_out flags the 59 -> 00 wrap in the
// same cycle the increment is requested, so a following field can chain.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic       carry_out,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic at_max;

  assign at_max    = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign carry_out = inc && at_max;

  // Field register: clear beats inc, units carry into tens at 9, tens wrap at 5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clear) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (units == MAX_UNITS) begin
        units <= 4'd0;
        tens  <= (tens == MAX_TENS) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch with run/pause/clear buttons and a
// per-field adjust mode. Optional lap-freeze feature is built in when the
// macro STOPWATCH_LAP_EN is defined (adds input btn_lap).
//
// state   | meaning
// IDLE    | stopped after reset or clear, ticks ignored
// RUN     | counting on tick_1hz
// PAUSE   | stopped, count held, pause edge resumes
// ADJUST  | sw_adj high, tick_adj steps the field chosen by sw_sel
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
`endif
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       adj,
  output logic [2:0] adj_sel,
  output logic       running
);

  sw_state_t  state;
  sw_state_t  state_nxt;

  logic       pause_q;
  logic       clear_q;
  logic       pause_edge;
  logic       clear_edge;

  logic       sec_inc;
  logic       min_inc;
  logic       sec_carry;
  logic       hour_carry_unused;

  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic [3:0] min_tens;
  logic [3:0] min_units;

  assign pause_edge = btn_pause && !pause_q;
  assign clear_edge = btn_clear && !clear_q;

  // Previous button levels, so a held button produces a single edge pulse.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      pause_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      pause_q <= btn_pause;
      clear_q <= btn_clear;
    end
  end

  // Next-state selection; adjust switch dominates, then clear, then pause toggling.
  always_comb begin
    state_nxt = state;
    if (sw_adj) begin
      state_nxt = ST_ADJUST;
    end else if (state == ST_ADJUST) begin
      state_nxt = ST_PAUSE;
    end else if (clear_edge) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (pause_edge) state_nxt = ST_RUN;
        ST_RUN:   if (pause_edge) state_nxt = ST_PAUSE;
        ST_PAUSE: if (pause_edge) state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      adj     <= 1'b0;
      adj_sel <= ADJ_SEL_NONE;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      adj     <= (state_nxt == ST_ADJUST);
      if (state_nxt == ST_ADJUST)
        adj_sel <= sw_sel ? ADJ_SEL_MIN : ADJ_SEL_SEC;
      else
        adj_sel <= ADJ_SEL_NONE;
    end
  end

  // Seconds carry into minutes only while running; adjust steps never chain.
  assign sec_inc = ((state == ST_RUN) && tick_1hz) ||
                   ((state == ST_ADJUST) && tick_adj && !sw_sel);
  assign min_inc = ((state == ST_RUN) && sec_carry) ||
                   ((state == ST_ADJUST) && tick_adj && sw_sel);

  bcd_mod60 u_sec (
    .clk       (clk),
    .rst_n     (btn_reset),
    .clear     (clear_edge),
    .inc       (sec_inc),
    .carry_out (sec_carry),
    .tens      (sec_tens),
    .units     (sec_units)
  );

  // Wrap past 59:59 simply returns to 00:00; the minute carry has no consumer.
  bcd_mod60 u_min (
    .clk       (clk),
    .rst_n     (btn_reset),
    .clear     (clear_edge),
    .inc       (min_inc),
    .carry_out (hour_carry_unused),
    .tens      (min_tens),
    .units     (min_units)
  );

`ifdef STOPWATCH_LAP_EN
  logic       lap_q;
  logic       lap_edge;
  logic       frozen;
  logic       frz_release;
  logic [3:0] snap_min_tens;
  logic [3:0] snap_min_units;
  logic [3:0] snap_sec_tens;
  logic [3:0] snap_sec_units;

  assign lap_edge = btn_lap && !lap_q;
  // Leaving RUN by any path (pause, clear, adjust) also drops the freeze.
  assign frz_release = lap_edge || pause_edge || clear_edge || sw_adj;

  // Lap button edge detector.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset)
      lap_q <= 1'b0;
    else
      lap_q <= btn_lap;
  end

  // Lap freeze: snapshot the displayed time while the counter keeps running.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      frozen         <= 1'b0;
      snap_min_tens  <= 4'd0;
      snap_min_units <= 4'd0;
      snap_sec_tens  <= 4'd0;
      snap_sec_units <= 4'd0;
    end else if (frozen) begin
      if (frz_release)
        frozen <= 1'b0;
    end else if ((state == ST_RUN) && lap_edge && !pause_edge &&
                 !clear_edge && !sw_adj) begin
      frozen         <= 1'b1;
      snap_min_tens  <= min_tens;
      snap_min_units <= min_units;
      snap_sec_tens  <= sec_tens;
      snap_sec_units <= sec_units;
    end
  end

  assign min_l = to_digit(frozen ? snap_min_tens  : min_tens);
  assign min_r = to_digit(frozen ? snap_min_units : min_units);
  assign sec_l = to_digit(frozen ? snap_sec_tens  : sec_tens);
  assign sec_r = to_digit(frozen ? snap_sec_units : sec_units);
`else
  assign min_l = to_digit(min_tens);
  assign min_r = to_digit(min_units);
  assign sec_l = to_digit(sec_tens);
  assign sec_r = to_digit(sec_units);
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl. The reference keeps the time as a
// plain seconds total (0..3599); directed scenarios are followed by a random
// phase. Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ADJ   = 3;

  logic       clk = 1'b0;
  logic       btn_reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_adj = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic       btn_lap = 1'b0;
  logic [4:0] min_l;
  logic [4:0] min_r;
  logic [4:0] sec_l;
  logic [4:0] sec_r;
  logic       adj;
  logic [2:0] adj_sel;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st;
  int m_cnt;
  int m_mm;
  int m_ss;
  bit m_pq;
  bit m_cq;
  bit m_selq;
  bit m_lq;
  bit m_frz;
  int m_snap;
  bit m_pe;
  bit m_ce;
  bit m_le;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .tick_1hz  (tick_1hz),
    .tick_adj  (tick_adj),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .sw_adj    (sw_adj),
    .sw_sel    (sw_sel),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (btn_lap),
`endif
    .min_l     (min_l),
    .min_r     (min_r),
    .sec_l     (sec_l),
    .sec_r     (sec_r),
    .adj       (adj),
    .adj_sel   (adj_sel),
    .running   (running)
  );

  // Reference model: time as a seconds total, state as a small integer.
  always @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      m_st = M_IDLE; m_cnt = 0; m_pq = 0; m_cq = 0; m_selq = 0;
      m_lq = 0; m_frz = 0; m_snap = 0;
    end else begin
      m_pe = btn_pause && !m_pq;
      m_ce = btn_clear && !m_cq;
      m_le = btn_lap && !m_lq;
`ifdef STOPWATCH_LAP_EN
      if (m_frz) begin
        if (m_le || m_pe || m_ce || sw_adj) m_frz = 0;
      end else if (m_st == M_RUN && m_le && !m_pe && !m_ce && !sw_adj) begin
        m_frz = 1;
        m_snap = m_cnt;
      end
`endif
      m_mm = m_cnt / 60;
      m_ss = m_cnt % 60;
      if (m_ce) m_cnt = 0;
      else if (m_st == M_RUN && tick_1hz) m_cnt = (m_cnt + 1) % 3600;
      else if (m_st == M_ADJ && tick_adj) begin
        if (sw_sel) m_mm = (m_mm + 1) % 60;
        else        m_ss = (m_ss + 1) % 60;
        m_cnt = m_mm * 60 + m_ss;
      end
      if (sw_adj) m_st = M_ADJ;
      else if (m_st == M_ADJ) m_st = M_PAUSE;
      else if (m_ce) m_st = M_IDLE;
      else if (m_pe) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
      m_pq = btn_pause; m_cq = btn_clear; m_lq = btn_lap; m_selq = sw_sel;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the reference.
  task automatic compare_all();
    int disp;
    int mm;
    int ss;
    disp = m_frz ? m_snap : m_cnt;
    mm = disp / 60;
    ss = disp % 60;
    chk("model.min_l", 32'(min_l), 32'(mm / 10));
    chk("model.min_r", 32'(min_r), 32'(mm % 10));
    chk("model.sec_l", 32'(sec_l), 32'(ss / 10));
    chk("model.sec_r", 32'(sec_r), 32'(ss % 10));
    chk("model.running", 32'(running), 32'(m_st == M_RUN));
    chk("model.adj", 32'(adj), 32'(m_st == M_ADJ));
    chk("model.adj_sel", 32'(adj_sel), (m_st != M_ADJ) ? 32'd0 : (m_selq ? 32'd2 : 32'd1));
  endtask

  // Hand-computed display expectation, independent of the model.
  task automatic lit(input string nm, input int mm, input int ss);
    chk({nm, ".min_l"}, 32'(min_l), 32'(mm / 10));
    chk({nm, ".min_r"}, 32'(min_r), 32'(mm % 10));
    chk({nm, ".sec_l"}, 32'(sec_l), 32'(ss / 10));
    chk({nm, ".sec_r"}, 32'(sec_r), 32'(ss % 10));
  endtask

  // One clock: drive at a falling edge, let the rising edge act, check at the next fall.
  task automatic step(input bit t1, input bit ta, input bit p, input bit c,
                      input bit a, input bit s);
    tick_1hz = t1; tick_adj = ta; btn_pause = p; btn_clear = c;
    sw_adj = a; sw_sel = s;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1 btn_reset = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    lit("reset", 0, 0);
    chk("reset.running", 32'(running), 32'd0);
    chk("reset.adj_sel", 32'(adj_sel), 32'd0);
    btn_reset = 1'b1;

    // Pause edge starts the count, three ticks -> 00:03.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    lit("start3", 0, 3);
    chk("start3.running", 32'(running), 32'd1);

    // Tick and pause edge together at 00:10.
    repeat (7) step(1, 0, 0, 0, 0, 0);
    lit("at10", 0, 10);
    step(1, 0, 1, 0, 0, 0);
    lit("tickpause", 0, 11);
    chk("tickpause.running", 32'(running), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Preload 59:58 in ADJUST, then run through the full wrap.
    step(0, 0, 0, 0, 1, 0);
    chk("enter_adj.adj", 32'(adj), 32'd1);
    repeat (47) step(0, 1, 0, 0, 1, 0);
    repeat (59) step(0, 1, 0, 0, 1, 1);
    lit("preload", 59, 58);
    chk("preload.adj_sel", 32'(adj_sel), 32'd2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit("wrap1", 59, 59);
    step(1, 0, 0, 0, 0, 0);
    lit("wrap2", 0, 0);

    // Seconds adjust wraps without carrying into minutes.
    step(0, 0, 0, 0, 1, 0);
    repeat (59) step(0, 1, 0, 0, 1, 0);
    lit("adj59", 0, 59);
    step(0, 1, 0, 0, 1, 0);
    lit("adjwrap", 0, 0);
    chk("adjwrap.adj", 32'(adj), 32'd1);
    chk("adjwrap.adj_sel", 32'(adj_sel), 32'd1);

    // 12:34 in PAUSE, clear held five cycles.
    repeat (12) step(0, 1, 0, 0, 1, 1);
    repeat (34) step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    lit("paused1234", 12, 34);
    repeat (5) step(0, 0, 0, 1, 0, 0);
    lit("clearheld", 0, 0);
    chk("clearheld.running", 32'(running), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit("idle_tick", 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("idle_to_run.running", 32'(running), 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // Held clear in ADJUST clears once; later adjust ticks still count.
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 1, 1, 0);
    lit("adjclearheld", 0, 2);
    chk("adjclearheld.adj", 32'(adj), 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // Clear and tick together in RUN.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit("run03", 0, 3);
    step(1, 0, 0, 1, 0, 0);
    lit("clrtick", 0, 0);
    chk("clrtick.running", 32'(running), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-count, between clock edges.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 btn_reset = 1'b0;
    #1 compare_all();
    lit("midreset", 0, 0);
    chk("midreset.running", 32'(running), 32'd0);
    @(negedge clk);
    btn_reset = 1'b1;
    repeat (2) step(1, 0, 0, 0, 0, 0);
    lit("after_reset", 0, 0);
    chk("after_reset.running", 32'(running), 32'd0);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze at 00:05, four ticks hidden, second lap shows 00:09.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    btn_lap = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    btn_lap = 1'b0;
    repeat (4) step(1, 0, 0, 0, 0, 0);
    lit("lapfrozen", 0, 5);
    btn_lap = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    btn_lap = 1'b0;
    lit("laprelease", 0, 9);
    step(0, 0, 0, 0, 0, 0);
`endif

    // Random phase: levels toggle occasionally, ticks pulse often.
    begin
      bit rp, rc, ra, rs;
      rp = 0; rc = 0; ra = 0; rs = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0)   rp = !rp;
        if ($urandom_range(0, 40) == 0)  rc = !rc;
        if ($urandom_range(0, 120) == 0) ra = !ra;
        if ($urandom_range(0, 15) == 0)  rs = !rs;
`ifdef STOPWATCH_LAP_EN
        if ($urandom_range(0, 10) == 0)  btn_lap = !btn_lap;
`endif
        step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rp, rc, ra, rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state on rising edge.
REQ-002 SHALL have port btn_reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port tick_1hz, input, 1: one-cycle count pulse from the clock divider.
REQ-004 SHALL have port tick_adj, input, 1: one-cycle 5 Hz adjust pulse from the clock divider.
REQ-005 SHALL have port btn_pause, input, 1: debounced, synchronous level; rising edge toggles run/pause.
REQ-006 SHALL have port btn_clear, input, 1: debounced, synchronous level; rising edge zeroes the count.
REQ-007 SHALL have port sw_adj, input, 1: level; 1 selects adjust mode.
REQ-008 SHALL have port sw_sel, input, 1: in adjust, 0 selects seconds and 1 selects minutes.
REQ-009 SHALL have ports min_l, min_r, sec_l, sec_r, each output, 5: BCD digits to the display block; bit 4 is always 0.
REQ-010 SHALL have port adj, output, 1: high in ADJUST.
REQ-011 SHALL have port adj_sel, output, 3: 3'b001 seconds, 3'b010 minutes, 3'b000 when not adjusting.
REQ-012 SHALL have port running, output, 1: high in RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE and ADJUST.
REQ-014 SHALL detect button edges as level & ~previous, using one register per button; a held button yields one pulse.
REQ-015 SHALL apply transitions in this priority order:
- sw_adj=1 -> ADJUST from any state;
- ADJUST with sw_adj=0 -> PAUSE;
- clear edge -> IDLE, except in ADJUST;
- IDLE + pause edge -> RUN;
- RUN + pause edge -> PAUSE;
- PAUSE + pause edge -> RUN.
REQ-016 SHALL, in RUN, increment mm:ss by 1 on each tick_1hz: sec_r carries into sec_l at 9; sec_l carries into min_r at 5 (sec 59 -> 00); minutes 59 -> 00; 59:59 -> 00:00.
REQ-017 SHALL, in ADJUST, increment only the selected field on tick_adj, 59 -> 00 with no carry into the other field; tick_1hz is ignored.
REQ-018 SHALL, on a clear edge, zero all digits the next cycle in every state, including ADJUST (state unchanged in ADJUST).
REQ-019 SHALL register all outputs: digits reflect a tick or clear one cycle after the pulse.
REQ-020 SHALL, when tick_1hz and a pause edge arrive in the same RUN cycle, count the tick and enter PAUSE.
REQ-021 SHALL, when clear and tick_1hz coincide, give priority to clear (result 00:00).
REQ-022 SHALL ignore ticks in IDLE and PAUSE; digits hold.

Reset
REQ-023 SHALL, while btn_reset=0, asynchronously force: state IDLE, all digits 0, adj=0, adj_sel=3'b000, running=0, edge registers 0.
REQ-024 SHALL, after reset is released mid-count, restart from IDLE at 00:00 with no residual edge pulse.

Configuration
REQ-025 SHALL, with STOPWATCH_LAP_EN defined, add input btn_lap (1 bit, debounced level). In RUN, a lap edge freezes the digit outputs at their current value while counting continues internally; a second lap edge, a pause edge or a clear edge releases the freeze.
REQ-026 SHALL, without STOPWATCH_LAP_EN, omit btn_lap and all freeze logic; digit outputs always track the count.

Structure
REQ-027 SHALL place the following in package stopwatch_pkg: state encodings, adj_sel encodings, and constants MAX_TENS=5, MAX_UNITS=9.
REQ-028 SHALL implement each mm and ss field as an instance of sub-module bcd_mod60 (inc, clear, carry_out, tens/units outputs), giving two instances.

Verification
REQ-029 SHALL cover: reset, then pause edge, then 3 tick_1hz -> 00:03, running=1.
REQ-030 SHALL cover: preload 59:58 via ADJUST, then RUN with 2 ticks -> 00:00 on the cycle after the second tick.
REQ-031 SHALL cover: ADJUST with sw_sel=0 at 00:59, then 1 tick_adj -> 00:00 (no minute carry); adj_sel=3'b001, adj=1.
REQ-032 SHALL cover: RUN at 00:10 with tick_1hz and pause edge in the same cycle -> 00:11, state PAUSE, running=0.
REQ-033 SHALL cover: PAUSE at 12:34 with btn_clear held 5 cycles -> one clear; 00:00, IDLE.
REQ-034 SHALL cover: with STOPWATCH_LAP_EN, RUN at 00:05 then lap edge and 4 ticks -> outputs hold 00:05; second lap edge -> outputs 00:09.
